// File: rtl/mul_acc_seq_pkg.sv
// Shared definitions for the sequential shift-add multiply-accumulate unit.
// Holds the default operand width, the FSM state encoding and the iteration count.
package mul_acc_seq_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    // One shift-add step per multiplier bit.
    localparam int unsigned ITER_COUNT = DEFAULT_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Counter width able to index 0..w-1, kept at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage : mul_acc_seq_pkg

// File: rtl/mul_acc_seq.sv
// Sequential shift-add multiply-accumulate: product = a*b + c, unsigned.
// WIDTH shift-add steps, one addend step, then a one-cycle done pulse.
module mul_acc_seq
    import mul_acc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int unsigned    CW        = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic                 load;

    logic [CW-1:0]        cnt_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     c_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_shift;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: clocked state uses <= so every register samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    load    = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN) || (state_q == ADD);
    assign done = (state_q == DONE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // acc_q holds {hi, lo}; lo starts as the multiplier and its LSB steers the add.
    always_comb begin
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_shift = {sum, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            a_q       <= '0;
            c_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
            a_q   <= a;
            c_q   <= c;
            acc_q <= {{WIDTH{1'b0}}, b};
        end else begin
            unique case (state_q)
                RUN: begin
                    acc_q <= acc_shift;
                    cnt_q <= (cnt_q == LAST_ITER) ? '0 : cnt_q + 1'b1;
                end
                ADD: begin
                    // Cannot overflow: (2^W-1)^2 + (2^W-1) < 2^(2W).
                    product_q <= acc_q + {{WIDTH{1'b0}}, c_q};
                end
                default: ;
            endcase
        end
    end

    assign product = product_q;

endmodule : mul_acc_seq

// File: tb/tb_mul_acc_seq.sv
// Self-checking bench for mul_acc_seq: a stimulus process queues expected products
// and done times, a monitor pops and compares whenever done is seen.
module tb_mul_acc_seq;

    localparam int W       = 16;
    localparam int LATENCY = W + 1;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   a, b, c;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [2*W-1:0] prod;
        int             edge_n;
    } exp_t;

    exp_t           exp_q[$];
    logic [2*W-1:0] last_prod;

    mul_acc_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .c       (c),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic, done observed LATENCY edges after the start edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ic, input bit noise);
        exp_t e;
        e.prod   = (2*W)'(ia) * (2*W)'(ib) + (2*W)'(ic);
        e.edge_n = cyc + 1 + LATENCY;
        exp_q.push_back(e);
        a = ia; b = ib; c = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        for (int i = 0; i < LATENCY; i++) begin
            if (noise) begin
                a     = W'($urandom);
                b     = W'($urandom);
                c     = W'($urandom);
                start = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("busy_in_done", busy, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Monitor: compares on every done, flags missing/unexpected pulses and product holding.
    always @(negedge clk) begin
        if (!reset) begin
            last_prod = '0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
                check("done_timeout", cyc, exp_q[0].edge_n);
                void'(exp_q.pop_front());
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("product", product, e.prod);
                    check("latency", cyc, e.edge_n);
                    last_prod = e.prod;
                end
            end else begin
                check("product_hold", product, last_prod);
            end
        end
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        a = '0; b = '0; c = '0;
        #2;
        check("reset_product", product, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        idle(3);
        reset = 1'b1;
        idle(2);

        // Directed cases
        issue(16'd3, 16'd8, 16'd0, 1'b0);
        idle(2);
        issue(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
        idle(1);
        issue(16'd3, 16'd5, 16'd4, 1'b0);
        issue(16'd0, 16'd8, 16'd3, 1'b0);
        idle(1);
        issue(16'd5, 16'd6, 16'd7, 1'b1);
        idle(1);
        issue(16'd9, 16'd9, 16'd9, 1'b0);
        issue(16'd4, 16'd4, 16'd0, 1'b0);
        idle(2);

        // Reset five edges into RUN: outputs clear at once, no done afterwards.
        a = 16'd100; b = 16'd100; c = 16'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(5);
        reset = 1'b0;
        #1;
        check("abort_product", product, '0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        idle(3);
        reset = 1'b1;
        idle(LATENCY + 3);
        issue(16'd2, 16'd7, 16'd1, 1'b0);
        idle(1);

        // Randomized traffic with ignored starts, input churn and back-to-back issues
        for (int n = 0; n < 40; n++) begin
            issue(W'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        for (int n = 0; n < 6; n++) begin
            logic [W-1:0] z;
            z = W'($urandom);
            issue((n % 2 == 0) ? '0 : z, (n % 2 == 0) ? z : '0, W'($urandom), 1'b0);
        end

        idle(LATENCY + 2);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_mul_acc_seq
